// File: rtl/uart_rx_framed.sv
// UART receiver with configurable framing (data bits, parity, stop bits),
// valid/ready output holding register, error flags and sticky overrun.
//
// Ports:
//   clock, reset  - rising-edge clock, async active-high reset
//   rx            - async serial input, idles high
//   data_out      - received word, LSB = first bit on the line
//   data_valid    - data_out and error flags hold an unconsumed frame
//   data_ready    - consumer accepts when data_valid && data_ready
//   parity_error  - held frame failed parity (0 when PARITY=0)
//   framing_error - held frame saw a low stop-bit sample
//   overrun       - sticky; a completed frame was dropped
//   busy          - FSM not idle

module uart_rx_framed #(
  parameter int CLK_SPEED = 5_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BAUD_TICK      = CLK_SPEED / BAUD_RATE;
  localparam int HALF_BAUD_TICK = BAUD_TICK / 2;
  localparam int CW = $clog2(BAUD_TICK) + 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_TICK - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BAUD_TICK - 1);
  localparam logic [BW-1:0] LAST_D  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_S  = BW'(STOP_BITS - 1);

  if (BAUD_TICK < 4) begin : g_bad_baud
    $error("uart_rx_framed: BAUD_TICK must be >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_framed: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_framed: STOP_BITS must be 1..2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_rx_framed: PARITY must be 0..2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } state_t;

  state_t state, state_nx;

  logic                 sync1, sync2;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_err;
  logic                 sample;
  logic                 done;
  logic                 par_x;
  logic                 pe_now;
  logic                 fe_now;

  assign rx_s = sync2;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sample   = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rx_s) state_nx = ST_START;
      end
      ST_START: begin
        if (cnt == HALF_M1) begin
          sample   = 1'b1;
          state_nx = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == FULL_M1) begin
          sample = 1'b1;
          if (bit_cnt == LAST_D)
            state_nx = (PARITY != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (cnt == FULL_M1) begin
          sample   = 1'b1;
          state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == FULL_M1) begin
          sample = 1'b1;
          if (bit_cnt == LAST_S) begin
            done     = 1'b1;
            state_nx = rx_s ? ST_IDLE : ST_BREAK_WAIT;
          end
        end
      end
      ST_BREAK_WAIT: begin
        if (rx_s) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Counter saturates instead of wrapping while parked in BREAK_WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      if (state == ST_IDLE || sample) cnt <= '0;
      else if (cnt != '1)              cnt <= cnt + 1'b1;
      if (sample) begin
        unique case (state)
          ST_START: begin
            bit_cnt  <= '0;
            stop_err <= 1'b0;
          end
          ST_DATA: begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= (bit_cnt == LAST_D) ? '0 : bit_cnt + 1'b1;
          end
          ST_PARITY: par_bit <= rx_s;
          ST_STOP: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (!rx_s) stop_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign par_x  = (^shreg) ^ par_bit;
  assign pe_now = (PARITY == 1) ? ~par_x :
                  (PARITY == 2) ?  par_x : 1'b0;
  assign fe_now = stop_err | ~rx_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else if (done) begin
      if (!data_valid || data_ready) begin
        data_out      <= shreg;
        parity_error  <= pe_now;
        framing_error <= fe_now;
        data_valid    <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Randomized self-checking bench for uart_rx_framed.
// DUT a: 8N1; DUT b: 7 data, even parity, 2 stop (BAUD_TICK=16).

module tb_uart_rx_framed;

  logic       clk;
  logic       rst;
  logic       rx_a, rx_b;
  logic       rdy_a, rdy_b;
  logic [7:0] dout_a;
  logic [6:0] dout_b;
  logic       dv_a, dv_b;
  logic       pe_a, pe_b;
  logic       fe_a, fe_b;
  logic       ovr_a, ovr_b;
  logic       busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  int         acc_a = 0;
  logic [7:0] last_d_a = 8'h0;
  logic       last_fe_a = 1'b0;

  uart_rx_framed #(
    .CLK_SPEED(16), .BAUD_RATE(1)
  ) u_a (
    .clock(clk), .reset(rst), .rx(rx_a),
    .data_out(dout_a), .data_valid(dv_a),
    .data_ready(rdy_a), .parity_error(pe_a),
    .framing_error(fe_a), .overrun(ovr_a),
    .busy(busy_a)
  );

  uart_rx_framed #(
    .CLK_SPEED(16), .BAUD_RATE(1),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) u_b (
    .clock(clk), .reset(rst), .rx(rx_b),
    .data_out(dout_b), .data_valid(dv_b),
    .data_ready(rdy_b), .parity_error(pe_b),
    .framing_error(fe_b), .overrun(ovr_b),
    .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (dv_a && rdy_a) begin
      acc_a     <= acc_a + 1;
      last_d_a  <= dout_a;
      last_fe_a <= fe_a;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic dv_of(input int d);
    return (d == 0) ? dv_a : dv_b;
  endfunction

  function automatic logic [7:0] dout_of(input int d);
    return (d == 0) ? dout_a : {1'b0, dout_b};
  endfunction

  function automatic logic pe_of(input int d);
    return (d == 0) ? pe_a : pe_b;
  endfunction

  function automatic logic fe_of(input int d);
    return (d == 0) ? fe_a : fe_b;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v);
    if (d == 0) rx_a = v;
    else        rx_b = v;
  endtask

  task automatic send_bits(input int d,
                           input logic [15:0] b,
                           input int n);
    for (int i = 0; i < n; i++) begin
      drive(d, b[i]);
      tick(16);
    end
    drive(d, 1'b1);
  endtask

  // Line image of one frame: start, data LSB first, parity, stops.
  function automatic void mk(input int d, input int data,
                             input bit pbit, input bit s0,
                             input bit s1,
                             output logic [15:0] b,
                             output int n);
    b = '1;
    b[0] = 1'b0;
    if (d == 0) begin
      for (int i = 0; i < 8; i++)
        b[1+i] = 1'((data >> i) & 1);
      b[9] = s0;
      n = 10;
    end else begin
      for (int i = 0; i < 7; i++)
        b[1+i] = 1'((data >> i) & 1);
      b[8]  = pbit;
      b[9]  = s0;
      b[10] = s1;
      n = 11;
    end
  endfunction

  // Expected result from frame content alone.
  function automatic void model(input int d, input int data,
                                input bit pbit, input bit s0,
                                input bit s1,
                                output logic [7:0] ed,
                                output bit epe,
                                output bit efe);
    int ones;
    if (d == 0) begin
      ed  = 8'(data % 256);
      epe = 1'b0;
      efe = !s0;
    end else begin
      ed   = 8'(data % 128);
      ones = 0;
      for (int i = 0; i < 7; i++) ones += (data >> i) & 1;
      ones += int'(pbit);
      epe  = (ones % 2) != 0;
      efe  = !s0 || !s1;
    end
  endfunction

  function automatic bit even_pbit(input int data);
    int ones;
    ones = 0;
    for (int i = 0; i < 7; i++) ones += (data >> i) & 1;
    return 1'((ones % 2) != 0);
  endfunction

  task automatic run_frame(input int d, input int data,
                           input bit pbit, input bit s0,
                           input bit s1, input string tag,
                           output int lat);
    logic [15:0] b;
    int n;
    int cyc;
    logic [7:0] ed, gd;
    bit epe, efe;
    logic gpe, gfe, dv_next;
    mk(d, data, pbit, s0, s1, b, n);
    model(d, data, pbit, s0, s1, ed, epe, efe);
    cyc = -1;
    gd = '0; gpe = 1'b0; gfe = 1'b0; dv_next = 1'b1;
    fork
      send_bits(d, b, n);
      begin
        for (int i = 1; i <= 260 && cyc < 0; i++) begin
          @(negedge clk);
          if (dv_of(d)) begin
            cyc = i;
            gd  = dout_of(d);
            gpe = pe_of(d);
            gfe = fe_of(d);
          end
        end
        if (cyc > 0) begin
          @(negedge clk);
          dv_next = dv_of(d);
        end
      end
    join
    chk({tag, "_seen"}, 32'(cyc > 0), 32'd1);
    chk({tag, "_data"}, 32'(gd), 32'(ed));
    chk({tag, "_pe"}, 32'(gpe), 32'(epe));
    chk({tag, "_fe"}, 32'(gfe), 32'(efe));
    chk({tag, "_pulse"}, 32'(dv_next), 32'd0);
    lat = cyc - 1;
    tick(20);
  endtask

  initial begin
    int lat;
    int cnt;
    int n0;
    bit saw_busy;
    logic [15:0] b;
    int n;
    int data;
    bit pb, s0, s1;

    rst = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1;
    rdy_a = 1'b1; rdy_b = 1'b1;
    tick(3);
    chk("rst_dv_a", 32'(dv_a), 0);
    chk("rst_dout_a", 32'(dout_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_ovr_a", 32'(ovr_a), 0);
    chk("rst_dv_b", 32'(dv_b), 0);
    chk("rst_err_b", 32'({pe_b, fe_b}), 0);
    rst = 1'b0;
    tick(5);
    chk("post_rst_busy", 32'(busy_a | busy_b), 0);

    // 8N1 timing and basic frame
    run_frame(0, 'hA5, 1'b0, 1'b1, 1'b1, "s1", lat);
    chk("s1_lat", 32'(lat), 32'(2 + 8 + 9 * 16 + 1));

    // even parity good and bad
    run_frame(1, 'h03, 1'b0, 1'b1, 1'b1, "s2a", lat);
    run_frame(1, 'h03, 1'b1, 1'b1, 1'b1, "s2b", lat);

    // glitch on the line is a false start
    drive(0, 1'b0);
    tick(5);
    drive(0, 1'b1);
    cnt = 0;
    saw_busy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dv_a) cnt++;
      if (busy_a) saw_busy = 1'b1;
    end
    chk("s3_nodv", 32'(cnt), 0);
    chk("s3_busy_seen", 32'(saw_busy), 1);
    chk("s3_idle", 32'(busy_a), 0);
    @(posedge clk); #1;
    run_frame(0, 'h3C, 1'b0, 1'b1, 1'b1, "s3ok", lat);

    // random frames on both formats
    for (int k = 0; k < 10; k++) begin
      data = int'($urandom_range(0, 255));
      s0 = ($urandom_range(0, 3) != 0);
      run_frame(0, data, 1'b0, s0, 1'b1, "rnd_a", lat);
      data = int'($urandom_range(0, 127));
      pb = 1'($urandom_range(0, 1));
      s0 = ($urandom_range(0, 3) != 0);
      s1 = ($urandom_range(0, 3) != 0);
      run_frame(1, data, pb, s0, s1, "rnd_b", lat);
    end

    // held-low line: one frame, then BREAK_WAIT
    rdy_a = 1'b1;
    n0 = acc_a;
    drive(0, 1'b0);
    tick(40 * 16);
    @(negedge clk);
    chk("s5_busy", 32'(busy_a), 1);
    chk("s5_frames", 32'(acc_a - n0), 1);
    chk("s5_data", 32'(last_d_a), 0);
    chk("s5_fe", 32'(last_fe_a), 1);
    @(posedge clk); #1;
    drive(0, 1'b1);
    tick(30);
    chk("s5_idle", 32'(busy_a), 0);
    chk("s5_frames2", 32'(acc_a - n0), 1);

    // overrun with no consumer
    rdy_a = 1'b0;
    mk(0, 'h11, 1'b0, 1'b1, 1'b1, b, n);
    send_bits(0, b, n);
    tick(20);
    @(negedge clk);
    chk("s4_dv1", 32'(dv_a), 1);
    chk("s4_d1", 32'(dout_a), 'h11);
    chk("s4_ovr0", 32'(ovr_a), 0);
    @(posedge clk); #1;
    mk(0, 'h22, 1'b0, 1'b1, 1'b1, b, n);
    send_bits(0, b, n);
    tick(20);
    @(negedge clk);
    chk("s4_dv2", 32'(dv_a), 1);
    chk("s4_d2", 32'(dout_a), 'h11);
    chk("s4_ovr1", 32'(ovr_a), 1);
    @(posedge clk); #1;
    n0 = acc_a;
    rdy_a = 1'b1;
    @(negedge clk);
    chk("s4_hold", 32'(dv_a), 1);
    @(negedge clk);
    chk("s4_cons", 32'(dv_a), 0);
    chk("s4_ovr_sticky", 32'(ovr_a), 1);
    chk("s4_acc_cnt", 32'(acc_a - n0), 1);
    chk("s4_acc_d", 32'(last_d_a), 'h11);

    // two stop bits, second low
    @(posedge clk); #1;
    rdy_b = 1'b0;
    mk(1, 'h55, even_pbit('h55), 1'b1, 1'b0, b, n);
    send_bits(1, b, n);
    tick(20);
    @(negedge clk);
    chk("s6_dv", 32'(dv_b), 1);
    chk("s6_d", 32'(dout_b), 'h55);
    chk("s6_fe", 32'(fe_b), 1);
    chk("s6_pe", 32'(pe_b), 0);

    // reset in the middle of data bits
    @(posedge clk); #1;
    drive(1, 1'b0); tick(16);
    drive(1, 1'b1); tick(16);
    drive(1, 1'b0); tick(16);
    chk("s6_busy_mid", 32'(busy_b), 1);
    rst = 1'b1;
    drive(1, 1'b1);
    #1;
    chk("s6r_dv_b", 32'(dv_b), 0);
    chk("s6r_dout_b", 32'(dout_b), 0);
    chk("s6r_err_b", 32'({pe_b, fe_b}), 0);
    chk("s6r_busy_b", 32'(busy_b), 0);
    chk("s6r_ovr_a", 32'(ovr_a), 0);
    chk("s6r_ovr_b", 32'(ovr_b), 0);
    tick(3);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (dv_b) cnt++;
    end
    chk("s6_noframe", 32'(cnt), 0);
    @(posedge clk); #1;
    rdy_b = 1'b1;
    run_frame(1, 'h2A, even_pbit('h2A), 1'b1, 1'b1, "s6post", lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 The module SHALL have parameter CLK_SPEED, default 5_000_000, meaning the clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 9600, meaning the serial bit rate.
REQ-003 The module SHALL have parameter DATA_BITS, default 8, legal 5..9, meaning data bits per frame.
REQ-004 The module SHALL have parameter PARITY, default 0, meaning 0=none, 1=odd, 2=even.
REQ-005 The module SHALL have parameter STOP_BITS, default 1, legal 1..2, meaning stop bits checked per frame.
REQ-006 The module SHALL derive BAUD_TICK=CLK_SPEED/BAUD_RATE and HALF_BAUD_TICK=BAUD_TICK/2, and elaboration SHALL fail if BAUD_TICK<4.
REQ-007 clock  in  1  single clock; all logic on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 rx  in  1  asynchronous serial line; idles high.
REQ-010 data_out  out  DATA_BITS  received word, LSB = first bit received.
REQ-011 data_valid  out  1  data_out and the error flags hold an unconsumed frame.
REQ-012 data_ready  in  1  consumer accepts the frame when data_ready and data_valid are both high.
REQ-013 parity_error  out  1  held frame failed the parity check; always 0 when PARITY=0.
REQ-014 framing_error  out  1  held frame had at least one stop-bit sample equal to 0.
REQ-015 overrun  out  1  sticky; a completed frame was dropped.
REQ-016 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 rx SHALL pass through a 2-flop synchronizer; every "rx" below means the synchronized value.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and BREAK_WAIT.
REQ-019 One tick counter, $clog2(BAUD_TICK)+1 bits wide, SHALL count every cycle outside IDLE and SHALL clear on each sample point; it SHALL never wrap.
REQ-020 IDLE: when rx=0 the FSM SHALL go to START; otherwise the counter SHALL be held at 0.
REQ-021 START: the midpoint sample SHALL occur HALF_BAUD_TICK cycles after leaving IDLE.
REQ-022 START: if the midpoint sample is rx=1 (false start), the FSM SHALL return to IDLE with no output change; otherwise it SHALL go to DATA.
REQ-023 Subsequent sample points SHALL be spaced exactly BAUD_TICK cycles apart.
REQ-024 DATA: the FSM SHALL take DATA_BITS samples, shifting them in LSB-first, then go to PARITY if PARITY!=0, else to STOP.
REQ-025 PARITY: the FSM SHALL take one sample; the check SHALL fail if XOR(data, parity bit) is 0 for odd parity, or 1 for even parity.
REQ-026 STOP: the FSM SHALL take STOP_BITS samples, and any sample equal to 0 SHALL set the frame's framing error.
REQ-027 After the final stop sample, the FSM SHALL go to IDLE if that sample was 1, else to BREAK_WAIT.
REQ-028 BREAK_WAIT SHALL stay until rx=1, then go to IDLE, and a held-low line SHALL produce exactly one frame.
REQ-029 Frame completion SHALL occur on the cycle of the final stop sample.
REQ-030 On frame completion, data_out, parity_error and framing_error SHALL load together, and data_valid SHALL be high on the next cycle.
REQ-031 Handshake: data_valid SHALL stay high and data_out and both error flags SHALL stay stable until a cycle with data_ready=1; data_valid SHALL clear the following cycle.
REQ-032 If a frame completes while data_valid=1 and data_ready=0, the new frame SHALL be discarded, the held frame SHALL be unchanged, and overrun SHALL be set.
REQ-033 If frame completion and a handshake occur in the same cycle, the new frame SHALL load, data_valid SHALL remain 1, and overrun SHALL be unchanged.
REQ-034 overrun SHALL clear only on reset.
REQ-035 Reception SHALL proceed independently of data_ready; there SHALL be no backpressure to the line.

Reset
REQ-036 While reset is high, the FSM SHALL be in IDLE, the counter and shift register SHALL be 0, and the synchronizer flops SHALL be 1.
REQ-037 While reset is high, data_out, data_valid, parity_error, framing_error, overrun and busy SHALL all be 0.
REQ-038 Reset asserted mid-frame SHALL abort the frame with no output.
REQ-039 After reset deasserts, the first frame SHALL be detected only on a new rx falling edge.

Verification (CLK_SPEED=16, BAUD_RATE=1, so BAUD_TICK=16)
REQ-040 Scenario 1 (8N1, data_ready=1): send 0xA5 -> data_out=0xA5 with data_valid high for exactly 1 cycle, both error flags 0, data_valid rising (2+8+9*16+1) cycles after the rx falling edge.
REQ-041 Scenario 2 (PARITY=2): send 0x03 with parity bit 0 -> parity_error=0; send 0x03 with parity bit 1 -> parity_error=1, data_out=0x03.
REQ-042 Scenario 3: drive rx low for 5 cycles, then high -> no data_valid, busy returns to 0, and the next valid frame is received correctly.
REQ-043 Scenario 4 (data_ready=0): send 0x11 then 0x22 -> data_out stays 0x11, overrun=1; raise data_ready -> 0x11 is consumed and overrun stays 1.
REQ-044 Scenario 5: hold rx=0 for 40 bit times -> one frame with data_out=0x00 and framing_error=1, FSM in BREAK_WAIT until rx=1, no second frame.
REQ-045 Scenario 6 (STOP_BITS=2, DATA_BITS=7): first stop bit 1, second stop bit 0 -> framing_error=1; assert reset mid-data -> all outputs 0 within the same cycle.
